// File: rtl/fix_pkg.sv
// Shared constants and state types for the FIX ingress framer.
package fix_pkg;

  localparam logic [7:0] SOH     = 8'h01;
  localparam logic [7:0] CH_8    = 8'h38;
  localparam logic [7:0] CH_EQ   = 8'h3D;
  localparam logic [7:0] CH_1    = 8'h31;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_DIG0 = 8'h30;

  typedef enum logic [1:0] {IDLE, START_EQ, BODY, TRAILER} fsm_state_t;
  typedef enum logic [1:0] {T0, T1, T10, T_MID} tag_state_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_DIG0) && (b <= 8'h39);
  endfunction

endpackage

// File: rtl/fix_word_packer.sv
// Packs committed message bytes little-endian into words and drives the
// registered write strobe with start/end/checksum-error markers.
module fix_word_packer
  import fix_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int BYTES_PER_WORD = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            i_byte,
  input  logic                  i_push,
  input  logic                  i_start,
  input  logic                  i_flush,
  input  logic                  i_err,
  input  logic                  i_full,
  output logic [DATA_WIDTH-1:0] o_word,
  output logic                  o_wr_en,
  output logic                  o_start_message,
  output logic                  o_end_message,
  output logic                  o_chk_err
);

  localparam int BPW = BYTES_PER_WORD;
  localparam int LW  = (BPW > 1) ? $clog2(BPW) : 1;
  localparam logic [LW-1:0] LAST_LANE  = LW'(BPW - 1);
  localparam logic [15:0]   START_PAIR = {CH_EQ, CH_8};

  logic [DATA_WIDTH-1:0] r_buf;
  logic [LW-1:0]         r_lane;
  logic                  r_start_pend;
  logic [7:0]            r_hold;
  logic                  r_hold_end;
  logic                  r_hold_err;
  logic [DATA_WIDTH-1:0] w_ins;

  // Lanes above the current one are always zero, so OR-insertion doubles as padding.
  assign w_ins = r_buf | (DATA_WIDTH'(i_byte) << {r_lane, 3'b000});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf           <= '0;
      r_lane          <= '0;
      r_start_pend    <= 1'b0;
      r_hold          <= '0;
      r_hold_end      <= 1'b0;
      r_hold_err      <= 1'b0;
      o_word          <= '0;
      o_wr_en         <= 1'b0;
      o_start_message <= 1'b0;
      o_end_message   <= 1'b0;
      o_chk_err       <= 1'b0;
    end else begin
      o_wr_en         <= 1'b0;
      o_start_message <= 1'b0;
      o_end_message   <= 1'b0;
      o_chk_err       <= 1'b0;
      if (BPW == 1) begin
        // Single-byte words: "8=" arrives in one cycle, so the stream runs one
        // byte behind and the closing SOH drains on the next non-full cycle.
        if (i_start) begin
          o_word          <= DATA_WIDTH'(CH_8);
          o_wr_en         <= 1'b1;
          o_start_message <= 1'b1;
          r_hold          <= CH_EQ;
          r_hold_end      <= 1'b0;
        end else if (i_push) begin
          o_word     <= DATA_WIDTH'(r_hold);
          o_wr_en    <= 1'b1;
          r_hold     <= i_byte;
          r_hold_end <= i_flush;
          r_hold_err <= i_err;
        end else if (r_hold_end && !i_full) begin
          o_word        <= DATA_WIDTH'(r_hold);
          o_wr_en       <= 1'b1;
          o_end_message <= 1'b1;
          o_chk_err     <= r_hold_err;
          r_hold_end    <= 1'b0;
        end
      end else begin
        if (i_start) begin
          if (BPW == 2) begin
            o_word          <= DATA_WIDTH'(START_PAIR);
            o_wr_en         <= 1'b1;
            o_start_message <= 1'b1;
            r_buf           <= '0;
            r_lane          <= '0;
            r_start_pend    <= 1'b0;
          end else begin
            r_buf        <= DATA_WIDTH'(START_PAIR);
            r_lane       <= LW'(2);
            r_start_pend <= 1'b1;
          end
        end else if (i_push) begin
          if (i_flush || (r_lane == LAST_LANE)) begin
            o_word          <= w_ins;
            o_wr_en         <= 1'b1;
            o_start_message <= r_start_pend;
            o_end_message   <= i_flush;
            o_chk_err       <= i_flush && i_err;
            r_buf           <= '0;
            r_lane          <= '0;
            r_start_pend    <= 1'b0;
          end else begin
            r_buf  <= w_ins;
            r_lane <= r_lane + 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: rtl/fix_msg_framer.sv
// FIX byte-stream framer: hunts "8=", tracks field tags to find the "10="
// trailer, verifies the checksum and feeds the word packer.
module fix_msg_framer
  import fix_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            byte_i,
  input  logic                  byte_valid_i,
  output logic                  byte_ready_o,
  input  logic                  full_i,
  output logic                  wr_cs_o,
  output logic                  wr_en_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  start_message_o,
  output logic                  end_message_o,
  output logic                  chk_err_o
);

  localparam int BYTES_PER_WORD = DATA_WIDTH / 8;

  fsm_state_t r_state, w_state_nxt;
  tag_state_t r_tag, w_tag_nxt;
  logic [7:0] r_sum, w_sum_nxt;
  logic [7:0] r_snap, w_snap_nxt;
  logic [7:0] r_rx, w_rx_nxt;
  logic [1:0] r_ndig, w_ndig_nxt;
  logic       r_fmt, w_fmt_nxt;
  logic       w_acc, w_push, w_start, w_flush, w_err, w_wr_en;
  logic [7:0] w_dval;

  assign byte_ready_o = !full_i;
  assign w_acc        = byte_valid_i && !full_i;
  assign w_dval       = byte_i - CH_DIG0;

  always_comb begin
    w_state_nxt = r_state;
    w_tag_nxt   = r_tag;
    w_sum_nxt   = r_sum;
    w_snap_nxt  = r_snap;
    w_rx_nxt    = r_rx;
    w_ndig_nxt  = r_ndig;
    w_fmt_nxt   = r_fmt;
    w_push      = 1'b0;
    w_start     = 1'b0;
    w_flush     = 1'b0;
    w_err       = 1'b0;
    if (w_acc) begin
      unique case (r_state)
        IDLE: begin
          if (byte_i == CH_8) w_state_nxt = START_EQ;
        end
        START_EQ: begin
          if (byte_i == CH_EQ) begin
            w_state_nxt = BODY;
            w_start     = 1'b1;
            w_sum_nxt   = CH_8 + CH_EQ;
            w_snap_nxt  = CH_8 + CH_EQ;
            w_tag_nxt   = T0;
            w_rx_nxt    = '0;
            w_ndig_nxt  = '0;
            w_fmt_nxt   = 1'b0;
          end else if (byte_i != CH_8) begin
            w_state_nxt = IDLE;
          end
        end
        BODY: begin
          w_push    = 1'b1;
          w_sum_nxt = r_sum + byte_i;
          if (byte_i == SOH) begin
            w_tag_nxt  = T0;
            w_snap_nxt = r_sum + byte_i;
          end else begin
            unique case (r_tag)
              T0:  w_tag_nxt = (byte_i == CH_1) ? T1 : T_MID;
              T1:  w_tag_nxt = (byte_i == CH_0) ? T10 : T_MID;
              T10: begin
                w_tag_nxt = T_MID;
                if (byte_i == CH_EQ) w_state_nxt = TRAILER;
              end
              default: w_tag_nxt = T_MID;
            endcase
          end
        end
        TRAILER: begin
          w_push    = 1'b1;
          w_sum_nxt = r_sum + byte_i;
          if (byte_i == SOH) begin
            w_flush     = 1'b1;
            w_err       = r_fmt || (r_rx != r_snap);
            w_state_nxt = IDLE;
            w_tag_nxt   = T0;
          end else if (is_digit(byte_i)) begin
            if (r_ndig == 2'd3) begin
              w_fmt_nxt = 1'b1;
            end else begin
              w_rx_nxt   = (r_rx * 8'd10) + w_dval;
              w_ndig_nxt = r_ndig + 2'd1;
            end
          end else begin
            w_fmt_nxt = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_tag   <= T0;
      r_sum   <= '0;
      r_snap  <= '0;
      r_rx    <= '0;
      r_ndig  <= '0;
      r_fmt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tag   <= w_tag_nxt;
      r_sum   <= w_sum_nxt;
      r_snap  <= w_snap_nxt;
      r_rx    <= w_rx_nxt;
      r_ndig  <= w_ndig_nxt;
      r_fmt   <= w_fmt_nxt;
    end
  end

  fix_word_packer #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BYTES_PER_WORD (BYTES_PER_WORD)
  ) u_packer (
    .clk             (clk),
    .rst             (rst),
    .i_byte          (byte_i),
    .i_push          (w_push),
    .i_start         (w_start),
    .i_flush         (w_flush),
    .i_err           (w_err),
    .i_full          (full_i),
    .o_word          (data_o),
    .o_wr_en         (w_wr_en),
    .o_start_message (start_message_o),
    .o_end_message   (end_message_o),
    .o_chk_err       (chk_err_o)
  );

  assign wr_en_o = w_wr_en;
  assign wr_cs_o = w_wr_en;

endmodule

// File: tb/tb_fix_msg_framer.sv
// Bench for fix_msg_framer: byte streams against a string-level FIX framing model.
module tb_fix_msg_framer;

  localparam int DW  = 32;
  localparam int BPW = DW / 8;

  typedef logic [7:0] bq_t [$];
  typedef struct packed {
    logic [DW-1:0] d;
    logic          sm;
    logic          em;
    logic          ce;
  } wr_t;
  typedef wr_t wrq_t [$];

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    byte_i = '0;
  logic          byte_valid_i = 1'b0;
  logic          byte_ready_o;
  logic          full_i = 1'b0;
  logic          wr_cs_o, wr_en_o, start_message_o, end_message_o, chk_err_o;
  logic [DW-1:0] data_o;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int unsigned n_orphan = 0;
  int unsigned n_cs_bad = 0;
  logic        acc_prev = 1'b0;
  wrq_t        got_q;
  wrq_t        exp_q;
  bq_t         stream;

  fix_msg_framer #(.DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .byte_i          (byte_i),
    .byte_valid_i    (byte_valid_i),
    .byte_ready_o    (byte_ready_o),
    .full_i          (full_i),
    .wr_cs_o         (wr_cs_o),
    .wr_en_o         (wr_en_o),
    .data_o          (data_o),
    .start_message_o (start_message_o),
    .end_message_o   (end_message_o),
    .chk_err_o       (chk_err_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) acc_prev = byte_valid_i && byte_ready_o && !rst;

  always @(negedge clk) begin
    if (wr_cs_o !== wr_en_o) n_cs_bad++;
    if (wr_en_o === 1'b1) begin
      got_q.push_back({data_o, start_message_o, end_message_o, chk_err_o});
      if (!acc_prev) n_orphan++;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired: simulation did not finish");
    $fatal(1);
  end

  // '|' stands for SOH in the readable stream strings.
  task automatic push_str(input string str);
    for (int k = 0; k < str.len(); k++)
      stream.push_back((str[k] == "|") ? 8'h01 : str[k]);
  endtask

  task automatic push_chk(input int from, input int unsigned delta, input bit four_digits);
    int unsigned s = 0;
    for (int k = from; k < stream.size(); k++) s += stream[k];
    s = (s + delta) % 256;
    if (four_digits) push_str($sformatf("10=0%03d|", s));
    else             push_str($sformatf("10=%03d|", s));
  endtask

  // Reference: find "8=", locate the "10=" field at a field boundary, sum every
  // byte before that field, parse the decimal trailer, then chunk the message.
  task automatic model(input bq_t s, output wrq_t e);
    int n, i, p, k, tr, j, nd;
    int unsigned sum, val;
    bit fmt, err;
    wr_t w;
    n = s.size(); i = 0; e = {};
    while (i + 1 < n) begin
      if (s[i] != 8'h38 || s[i+1] != 8'h3D) begin i++; continue; end
      p = i; tr = -1; k = p + 2;
      while (k < n && tr < 0) begin
        if (k + 2 < n && s[k] == 8'h31 && s[k+1] == 8'h30 && s[k+2] == 8'h3D) tr = k;
        else begin
          while (k < n && s[k] != 8'h01) k++;
          k++;
        end
      end
      if (tr < 0) break;
      sum = 0;
      for (int q = p; q < tr; q++) sum += s[q];
      j = tr + 3; val = 0; nd = 0; fmt = 0;
      while (j < n && s[j] != 8'h01) begin
        if (s[j] >= 8'h30 && s[j] <= 8'h39) begin
          val = (val * 10 + s[j] - 8'h30) % 256;
          nd++;
        end else fmt = 1;
        j++;
      end
      if (j >= n) break;
      err = fmt || (nd > 3) || (val != sum % 256);
      for (int q = p; q <= j; q += BPW) begin
        w = '0;
        for (int l = 0; l < BPW; l++) if (q + l <= j) w.d[8*l +: 8] = s[q+l];
        w.sm = (q == p);
        w.em = (q + BPW > j);
        w.ce = w.em && err;
        e.push_back(w);
      end
      i = j + 1;
    end
  endtask

  task automatic drive(input bq_t s, input int gap_pct, input int full_pct);
    int idx = 0;
    int budget = 30 * s.size() + 100;
    while (idx < s.size() && budget > 0) begin
      @(negedge clk);
      byte_valid_i = ($urandom_range(99) >= gap_pct);
      full_i       = ($urandom_range(99) < full_pct);
      byte_i       = s[idx];
      @(posedge clk);
      if (byte_valid_i && byte_ready_o) idx++;
      budget--;
    end
    @(negedge clk);
    byte_valid_i = 1'b0;
    full_i       = 1'b0;
    if (idx < s.size()) begin
      n_checks++;
      $display("FAIL drive_timeout sent %0d required %0d bytes", idx, s.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      full_i = c[0];
      byte_valid_i = 1'b1;
      byte_i = (c < 3) ? 8'h38 : 8'h3D;
      #1;
      n_checks++;
      if ({wr_en_o, wr_cs_o, start_message_o, end_message_o, chk_err_o, data_o} !== '0 ||
          byte_ready_o !== !full_i)
        $display("FAIL reset_outputs cycle %0d got wr=%b cs=%b sm=%b em=%b ce=%b d=%h rdy=%b want zeros rdy=%b",
                 c, wr_en_o, wr_cs_o, start_message_o, end_message_o, chk_err_o, data_o, byte_ready_o, !full_i);
      else n_pass++;
    end
    @(negedge clk);
    byte_valid_i = 1'b0; full_i = 1'b0; rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    wr_t want [3];
    want[0] = {32'h01413D38, 1'b1, 1'b0, 1'b0};
    want[1] = {32'h313D3031, 1'b0, 1'b0, 1'b0};
    want[2] = {32'h00013338, 1'b0, 1'b1, 1'b0};
    stream = {}; got_q = {};
    push_str("8=A|10=183|");
    drive(stream, 0, 0);
    n_checks++;
    if (got_q.size() != 3) $display("FAIL basic_count got %0d want 3", got_q.size());
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (k >= got_q.size()) $display("FAIL basic_word%0d missing want %h", k, want[k]);
      else if (got_q[k] !== want[k]) $display("FAIL basic_word%0d got %h want %h", k, got_q[k], want[k]);
      else n_pass++;
    end
  endtask

  task automatic test_bad_checksum();
    wr_t want [3];
    want[0] = {32'h01413D38, 1'b1, 1'b0, 1'b0};
    want[1] = {32'h313D3031, 1'b0, 1'b0, 1'b0};
    want[2] = {32'h00013438, 1'b0, 1'b1, 1'b1};
    stream = {}; got_q = {};
    push_str("8=A|10=184|");
    drive(stream, 20, 20);
    n_checks++;
    if (got_q.size() != 3) $display("FAIL badchk_count got %0d want 3", got_q.size());
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (k >= got_q.size()) $display("FAIL badchk_word%0d missing want %h", k, want[k]);
      else if (got_q[k] !== want[k]) $display("FAIL badchk_word%0d got %h want %h", k, got_q[k], want[k]);
      else n_pass++;
    end
  endtask

  task automatic test_garbage();
    stream = {}; got_q = {};
    push_str("X88Q8=A|10=183|");
    model(stream, exp_q);
    drive(stream, 0, 0);
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL garbage_count got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= got_q.size()) $display("FAIL garbage_word%0d missing want %h", k, exp_q[k]);
      else if (got_q[k] !== exp_q[k]) $display("FAIL garbage_word%0d got %h want %h", k, got_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_stall();
    bq_t pre, post;
    wr_t want [3];
    want[0] = {32'h01413D38, 1'b1, 1'b0, 1'b0};
    want[1] = {32'h313D3031, 1'b0, 1'b0, 1'b0};
    want[2] = {32'h00013338, 1'b0, 1'b1, 1'b0};
    stream = {}; got_q = {};
    push_str("8=A|10=183|");
    pre  = stream[0:5];
    post = stream[6:$];
    drive(pre, 0, 0);
    for (int c = 0; c < 5; c++) begin
      full_i = 1'b1; byte_valid_i = 1'b1; byte_i = post[0];
      @(posedge clk);
      @(negedge clk);
      n_checks++;
      if (byte_ready_o !== 1'b0 || wr_en_o !== 1'b0)
        $display("FAIL stall_cycle%0d got rdy=%b wr=%b want rdy=0 wr=0", c, byte_ready_o, wr_en_o);
      else n_pass++;
    end
    full_i = 1'b0; byte_valid_i = 1'b0;
    drive(post, 0, 0);
    n_checks++;
    if (got_q.size() != 3) $display("FAIL stall_count got %0d want 3", got_q.size());
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (k >= got_q.size()) $display("FAIL stall_word%0d missing want %h", k, want[k]);
      else if (got_q[k] !== want[k]) $display("FAIL stall_word%0d got %h want %h", k, got_q[k], want[k]);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid();
    wr_t want [3];
    int ends = 0;
    want[0] = {32'h01413D38, 1'b1, 1'b0, 1'b0};
    want[1] = {32'h313D3031, 1'b0, 1'b0, 1'b0};
    want[2] = {32'h00013338, 1'b0, 1'b1, 1'b0};
    stream = {}; got_q = {};
    push_str("8=A|1");
    drive(stream, 0, 0);
    rst = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({wr_en_o, wr_cs_o, start_message_o, end_message_o, chk_err_o, data_o} !== '0)
        $display("FAIL midreset_outputs cycle %0d got wr=%b sm=%b em=%b ce=%b d=%h want zeros",
                 c, wr_en_o, start_message_o, end_message_o, chk_err_o, data_o);
      else n_pass++;
    end
    rst = 1'b0;
    foreach (got_q[k]) if (got_q[k].em) ends++;
    n_checks++;
    if (ends != 0) $display("FAIL midreset_partial_end got %0d end writes want 0", ends);
    else n_pass++;
    stream = {}; got_q = {};
    push_str("0=9|8=A|10=183|");
    drive(stream, 10, 10);
    n_checks++;
    if (got_q.size() != 3) $display("FAIL midreset_count got %0d want 3", got_q.size());
    else n_pass++;
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if (k >= got_q.size()) $display("FAIL midreset_word%0d missing want %h", k, want[k]);
      else if (got_q[k] !== want[k]) $display("FAIL midreset_word%0d got %h want %h", k, got_q[k], want[k]);
      else n_pass++;
    end
  endtask

  task automatic test_lookalike();
    stream = {}; got_q = {};
    push_str("8=A|110=5|");
    push_chk(0, 0, 1'b0);
    model(stream, exp_q);
    drive(stream, 0, 0);
    n_checks++;
    if (got_q.size() != 5) $display("FAIL lookalike_count got %0d want 5", got_q.size());
    else n_pass++;
    n_checks++;
    if (got_q.size() == 0 || got_q[got_q.size()-1].em !== 1'b1 || got_q[got_q.size()-1].ce !== 1'b0)
      $display("FAIL lookalike_end got last=%h want end=1 err=0", (got_q.size() > 0) ? got_q[got_q.size()-1] : '0);
    else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= got_q.size()) $display("FAIL lookalike_word%0d missing want %h", k, exp_q[k]);
      else if (got_q[k] !== exp_q[k]) $display("FAIL lookalike_word%0d got %h want %h", k, got_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    stream = {}; got_q = {};
    push_str("8=A|10=183|8=A|10=184|88=B|10=");
    push_chk(23, 0, 1'b0);
    model(stream, exp_q);
    drive(stream, 0, 0);
    n_checks++;
    if (got_q.size() != exp_q.size()) $display("FAIL b2b_count got %0d want %0d", got_q.size(), exp_q.size());
    else n_pass++;
    for (int k = 0; k < exp_q.size(); k++) begin
      n_checks++;
      if (k >= got_q.size()) $display("FAIL b2b_word%0d missing want %h", k, exp_q[k]);
      else if (got_q[k] !== exp_q[k]) $display("FAIL b2b_word%0d got %h want %h", k, got_q[k], exp_q[k]);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    string tags [6] = '{"35", "49", "110", "1", "101", "0"};
    string vals = "AB10=Z";
    string junk = "XQ8Z9";
    int start, mode;
    for (int r = 0; r < 4; r++) begin
      stream = {}; got_q = {};
      for (int m = 0; m < 5; m++) begin
        for (int g = $urandom_range(3); g > 0; g--) stream.push_back(junk[$urandom_range(4)]);
        start = stream.size();
        push_str("8=");
        for (int f = $urandom_range(1, 4); f > 0; f--) begin
          push_str({tags[$urandom_range(5)], "="});
          for (int v = $urandom_range(3); v > 0; v--) stream.push_back(vals[$urandom_range(5)]);
          push_str("|");
        end
        mode = $urandom_range(3);
        case (mode)
          0: push_chk(start, 0, 1'b0);
          1: push_chk(start, $urandom_range(1, 255), 1'b0);
          2: push_str("10=1A3|");
          default: push_chk(start, 0, 1'b1);
        endcase
      end
      model(stream, exp_q);
      drive(stream, 30, 30);
      n_checks++;
      if (got_q.size() != exp_q.size()) $display("FAIL rand%0d_count got %0d want %0d", r, got_q.size(), exp_q.size());
      else n_pass++;
      for (int k = 0; k < exp_q.size(); k++) begin
        n_checks++;
        if (k >= got_q.size()) $display("FAIL rand%0d_word%0d missing want %h", r, k, exp_q[k]);
        else if (got_q[k] !== exp_q[k]) $display("FAIL rand%0d_word%0d got %h want %h", r, k, got_q[k], exp_q[k]);
        else n_pass++;
      end
    end
  endtask

  task automatic test_strobes();
    n_checks++;
    if (n_orphan != 0) $display("FAIL write_timing got %0d writes without a preceding accept want 0", n_orphan);
    else n_pass++;
    n_checks++;
    if (n_cs_bad != 0) $display("FAIL cs_equals_en got %0d cycles wr_cs_o!=wr_en_o want 0", n_cs_bad);
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bad_checksum();
    test_garbage();
    test_stall();
    test_reset_mid();
    test_lookalike();
    test_back_to_back();
    test_random();
    test_strobes();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
